clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
- Bank of NUM_CH independent programmable clock dividers.
- Each channel produces a 50%-duty divided clock and a one-cycle tick strobe at every toggle.
- Sits between the board clock and slow consumers such as display scan, debouncers and blinkers.
- Replaces fixed-divisor dividers; divisors are runtime-programmable through a ready/valid config port and update glitch-free.

Parameters:
- NUM_CH, 4: number of divider channels, 1..16.
- CNT_W, 20: counter and divisor width in bits.
- DEF_DIV, 100000: divisor loaded into every channel at reset; must fit in CNT_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  divisor write request.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_div  in  CNT_W  new divisor value.
- cfg_ready  out  1  write accepted this cycle when high together with cfg_valid.
- clk_out  out  NUM_CH  divided clocks.
- tick  out  NUM_CH  one-cycle strobe coinciding with each clk_out toggle.

Behaviour:
- Reset (async assert, sync deassert by clk):
  - every cnt=0, div=DEF_DIV, pend=0, clk_out=0, tick=0.
  - cfg_ready is combinational, so it reads 1 during reset.
- Channel running (en[i]=1):
  - If cnt==div: cnt<=0, clk_out[i] toggles, tick[i]<=1.
  - Otherwise: cnt<=cnt+1, tick[i]<=0.
  - Output period is 2*(div+1) clk cycles.
  - Output changes are registered; first toggle occurs div+1 cycles after en rises.
- Channel stopped (en[i]=0): cnt<=0, clk_out[i]<=0, tick[i]<=0 on the next edge. Re-enabling restarts phase from zero.
- div==0: clk_out toggles every cycle (clk/2) and tick stays high continuously.
- cnt never exceeds div. No wrap past 2^CNT_W-1 is possible because div is at most 2^CNT_W-1.
- Config handshake:
  - cfg_ready = ~pend[cfg_ch] (combinational), forced 0 if cfg_ch>=NUM_CH.
  - Transfer occurs when cfg_valid & cfg_ready: pend_div[ch]<=cfg_div and pend[ch]<=1.
  - When the target channel is stopped, div<=cfg_div directly and pend stays 0.
- Pending apply: on a running channel's next terminal count (cnt==div with pend=1):
  - div<=pend_div, pend<=0.
  - That terminal count uses the old div, so no runt or stretched half-period is produced.
- Simultaneous events:
  - Write accepted in the same cycle as a terminal count becomes pending and is applied at the following terminal count.
  - If en falls while pend=1, pend_div is applied at that edge and pend is cleared.
- Writes to different channels in consecutive cycles are all accepted. A second write to a still-pending channel is stalled (cfg_ready=0).
- Reset mid-operation: all state returns to reset values immediately. Pending writes are discarded.

Optional Feature:
- Macro CLK_DIV_BANK_SYNC_EN.
- Defined: en passes through a 2-flop synchronizer per bit before use, adding exactly 2 cycles of latency on both enable and disable. Synchronizer flops reset to 0.
- Undefined: en is used directly and must be synchronous to clk.

Decomposition:
- Package clk_div_pkg:
  - CNT_W default and DEF_DIV default constants.
  - typedef div_t (logic [CNT_W-1:0]).
  - typedef ch_idx_t.
- Sub-module clk_div_ch: one channel holding cnt, div, pend, pend_div, clk_out and tick, with inputs en, load_valid and load_div, and output busy (=pend).
- Top clk_div_bank: generate-loop instantiation, cfg_ch decode, cfg_ready mux, optional synchronizer.

Test Plan:
- Reset with DEF_DIV=4, NUM_CH=2, en=2'b01: ch0 clk_out toggles every 5 cycles (period 10), tick high 1 cycle at each toggle; ch1 clk_out and tick stay 0.
- ch0 running div=4, write cfg_div=1 mid-period: cfg_ready=1 on accept, then 0 until the next terminal count. The old 5-cycle half-period completes, then half-periods are 2 cycles.
- Write issued on the exact terminal-count cycle: new div takes effect only after one further full old half-period. A second write to the same channel while pending is stalled.
- Set div=0 on a stopped channel, then en=1: clk_out toggles every cycle and tick stays 1.
- en drop mid-count with a pending write: clk_out=0 and cnt=0 next cycle. After en rises again, the new div is active and the first toggle lands at new div+1 cycles.
- Assert rst_n=0 asynchronously mid-period: outputs are 0 before the next clk edge. With CLK_DIV_BANK_SYNC_EN defined, the en-to-first-toggle latency grows by exactly 2 cycles.

Source files
------------

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and types for the programmable clock-divider bank.
//   CNT_W_DEF   : default counter/divisor width
//   DEF_DIV_DEF : default divisor loaded into every channel at reset
//   MAX_CH      : largest supported channel count
//   div_t       : divisor/counter value at the default width
//   ch_idx_t    : channel index wide enough for MAX_CH channels
//   ch_idx_w()  : channel-select width for a given channel count (min 1 bit)
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int CNT_W_DEF   = 20;
    localparam int DEF_DIV_DEF = 100000;
    localparam int MAX_CH      = 16;

    typedef logic [CNT_W_DEF-1:0]       div_t;
    typedef logic [$clog2(MAX_CH)-1:0]  ch_idx_t;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// -----------------------------------------------------------------------------
// clk_div_ch
// One divider channel: 50%-duty divided clock plus a one-cycle tick at every
// toggle. A new divisor is either loaded directly (channel stopped) or held
// pending and applied at the next terminal count so no half-period is cut
// short or stretched.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   en          : run enable (synchronous to clk)
//   load_valid  : accept load_div this cycle (only issued while busy=0)
//   load_div    : new divisor
//   clk_out     : divided clock, period 2*(div+1)
//   tick        : high for the cycle in which clk_out has just toggled
//   busy        : a divisor write is pending
// -----------------------------------------------------------------------------
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_div,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_div      <= CNT_W'(DEF_DIV);
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            // Stopped channel has no phase to protect: take the divisor now,
            // and flush any write left pending when en dropped.
            if (load_valid) begin
                r_div  <= load_div;
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_div  <= r_pend_div;
                r_pend <= 1'b0;
            end
        end else begin
            if (r_cnt == r_div) begin
                r_cnt  <= '0;
                r_clk  <= ~r_clk;
                r_tick <= 1'b1;
                if (r_pend) begin
                    r_div  <= r_pend_div;
                    r_pend <= 1'b0;
                end
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
            // Placed last so a write landing on a terminal count stays
            // pending until the following terminal count.
            if (load_valid) begin
                r_pend_div <= load_div;
                r_pend     <= 1'b1;
            end
        end
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;
    assign busy    = r_pend;

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Bank of NUM_CH independent programmable clock dividers with a ready/valid
// divisor-write port.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : per-channel run enable
//   cfg_valid  : divisor write request
//   cfg_ch     : target channel
//   cfg_div    : new divisor
//   cfg_ready  : write accepted when high with cfg_valid (combinational)
//   clk_out    : divided clocks
//   tick       : one-cycle strobe at each clk_out toggle
// Build option:
//   CLK_DIV_BANK_SYNC_EN : when defined, en passes through a 2-flop
//                          synchronizer per bit (2 cycles extra latency).
// -----------------------------------------------------------------------------
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           en,
    input  logic                        cfg_valid,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]            cfg_div,
    output logic                        cfg_ready,
    output logic [NUM_CH-1:0]           clk_out,
    output logic [NUM_CH-1:0]           tick
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] w_en;
    logic [NUM_CH-1:0] w_busy;
    logic [NUM_CH-1:0] w_load;
    logic              w_ready;

`ifdef CLK_DIV_BANK_SYNC_EN
    logic [NUM_CH-1:0] r_en_s1;
    logic [NUM_CH-1:0] r_en_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_s1 <= '0;
            r_en_s2 <= '0;
        end else begin
            r_en_s1 <= en;
            r_en_s2 <= r_en_s1;
        end
    end

    assign w_en = r_en_s2;
`else
    assign w_en = en;
`endif

    // Unmatched (out-of-range) channel indices leave ready at 0.
    always_comb begin
        w_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_ready = ~w_busy[i];
            end
        end
    end

    assign cfg_ready = w_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g] = cfg_valid & w_ready & (cfg_ch == CH_W'(g));

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (w_en[g]),
            .load_valid (w_load[g]),
            .load_div   (cfg_div),
            .clk_out    (clk_out[g]),
            .tick       (tick[g]),
            .busy       (w_busy[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Table-driven bench for clk_div_bank (NUM_CH=2, DEF_DIV=4). Each table row is
// one clock cycle: inputs, expected cfg_ready before the edge, and which
// channels are expected to toggle at the edge. Expected clk_out levels are
// accumulated from the toggle pattern while the table is built.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 20;
    localparam int DEF_DIV = 4;

    logic              clk;
    logic              rst_n;
    logic [1:0]        en;
    logic              cfg_valid;
    logic [0:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic [1:0]        clk_out;
    logic [1:0]        tick;

    clk_div_bank #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       en;
        logic             cv;
        logic             ch;
        logic [CNT_W-1:0] d;
        logic             rdy;
        logic [1:0]       clk_e;
        logic [1:0]       tk_e;
    } vec_t;

    vec_t        vecs[$];
    logic [3:0]  sb[$];
    logic [1:0]  b_clk;
    int          total;
    int          bad;

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, got, exp);
        end
    endtask

    // One cycle: t0/t1 mark a toggle of channel 0/1 at this edge.
    task automatic add(input logic [1:0] e, input logic cv, input logic ch,
                       input logic [CNT_W-1:0] d, input logic rdy,
                       input logic t0, input logic t1);
        vec_t v;
        logic [1:0] t;
        t = {t1, t0};
        for (int i = 0; i < 2; i++) begin
            if (!e[i])     b_clk[i] = 1'b0;
            else if (t[i]) b_clk[i] = ~b_clk[i];
        end
        v.en = e; v.cv = cv; v.ch = ch; v.d = d; v.rdy = rdy;
        v.clk_e = b_clk;
        v.tk_e  = t & e;
        vecs.push_back(v);
    endtask

    // Channel 0 running alone from cnt=0 with divisor dv: toggle every dv+1.
    task automatic run0(input int n, input int dv);
        for (int k = 1; k <= n; k++) begin
            add(2'b01, 1'b0, 1'b0, '0, 1'b1, (k % (dv + 1)) == 0, 1'b0);
        end
    endtask

    task automatic apply(input int base);
        logic [3:0] e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            en        = vecs[i].en;
            cfg_valid = vecs[i].cv;
            cfg_ch    = vecs[i].ch;
            cfg_div   = vecs[i].d;
            #1;
            chk("cfg_ready", base + i, {31'd0, cfg_ready}, {31'd0, vecs[i].rdy});
            sb.push_back({vecs[i].clk_e, vecs[i].tk_e});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("clk_out", base + i, {30'd0, clk_out}, {30'd0, e[3:2]});
            chk("tick",    base + i, {30'd0, tick},    {30'd0, e[1:0]});
        end
        vecs.delete();
    endtask

    initial begin
        total = 0; bad = 0; b_clk = 2'b00;
        rst_n = 1'b0; en = 2'b00; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_out",   -1, {30'd0, clk_out}, 32'd0);
        chk("rst_tick",      -1, {30'd0, tick},    32'd0);
        chk("rst_cfg_ready", -1, {31'd0, cfg_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Default divisor 4: period 10, ch1 idle.
        run0(20, 4);
        // Mid-period write of 1: old half-period completes, then 2-cycle halves.
        add(2'b01, 1'b0, 1'b0, 20'd0, 1'b1, 1'b0, 1'b0);
        add(2'b01, 1'b1, 1'b0, 20'd1, 1'b1, 1'b0, 1'b0);
        add(2'b01, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0);
        add(2'b01, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0);
        add(2'b01, 1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 1'b0);
        run0(8, 1);
        // Write on the terminal-count cycle, plus a stalled second write.
        add(2'b01, 1'b0, 1'b0, 20'd0, 1'b1, 1'b0, 1'b0);
        add(2'b01, 1'b1, 1'b0, 20'd3, 1'b1, 1'b1, 1'b0);
        add(2'b01, 1'b1, 1'b0, 20'd7, 1'b0, 1'b0, 1'b0);
        add(2'b01, 1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 1'b0);
        run0(8, 3);
        // div=0 loaded into stopped ch1, then run: toggles every cycle.
        add(2'b00, 1'b1, 1'b1, 20'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) add(2'b10, 1'b0, 1'b1, 20'd0, 1'b1, 1'b0, 1'b1);
        add(2'b00, 1'b0, 1'b0, 20'd0, 1'b1, 1'b0, 1'b0);
        // en drop with a pending write of 2 on ch0.
        run0(4, 3);
        add(2'b01, 1'b0, 1'b0, 20'd0, 1'b1, 1'b0, 1'b0);
        add(2'b01, 1'b1, 1'b0, 20'd2, 1'b1, 1'b0, 1'b0);
        add(2'b00, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0);
        add(2'b00, 1'b0, 1'b0, 20'd0, 1'b1, 1'b0, 1'b0);
        run0(6, 2);
        run0(4, 2);
        // Leave a write of 0 pending before the mid-period reset.
        add(2'b01, 1'b1, 1'b0, 20'd0, 1'b1, 1'b0, 1'b0);
        apply(0);

        // Asynchronous reset between edges with clk_out[0] high.
        @(negedge clk);
        cfg_valid = 1'b0;
        en = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clk_out",   -2, {30'd0, clk_out},   32'd0);
        chk("async_tick",      -2, {30'd0, tick},      32'd0);
        chk("async_cfg_ready", -2, {31'd0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("held_clk_out", -3, {30'd0, clk_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b_clk = 2'b00;

        // After reset: pending write discarded, default divisor 4 again.
        run0(12, 4);
        apply(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
